// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bus bundle shared by the rggen register slice and its neighbours.
// A zero ID_WIDTH is clipped to a 1-bit ID field.
interface rggen_axi4lite_if #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int ID_W = (ID_WIDTH > 0) ? ID_WIDTH : 1;

  logic                     awvalid;
  logic                     awready;
  logic [ID_W-1:0]          awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [ID_W-1:0]          bid;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ID_W-1:0]          arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [ID_W-1:0]          rid;
  logic [1:0]               rresp;
  logic [BUS_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, awid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arprot, input arready,
    input rvalid, rid, rresp, rdata, output rready
  );

  modport slave (
    input awvalid, awid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bid, bresp, input bready,
    input arvalid, arid, araddr, arprot, output arready,
    output rvalid, rid, rresp, rdata, input rready
  );
endinterface

// File: rtl/rggen_axi4lite_register_slice.sv
// AXI4-Lite register slice: one independent circular FIFO per channel,
// a depth of 0 turns that channel into a plain wire-through.
module rggen_axi4lite_register_slice_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);
  if (DEPTH == 0) begin : g_through
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign in_ready       = out_ready;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
    assign empty          = 1'b1;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    // Ready is a function of occupancy only, so no ready path crosses the slice.
    assign in_ready  = (count != CW'(DEPTH)) && !rst;
    assign out_valid = (count != '0);
    assign out_data  = mem[rptr];
    assign empty     = (count == '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (push) begin
          mem[wptr] <= in_data;
          wptr      <= next_ptr(wptr);
        end
        if (pop) begin
          rptr <= next_ptr(rptr);
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

module rggen_axi4lite_register_slice #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int AW_DEPTH      = 2,
  parameter int W_DEPTH       = 2,
  parameter int B_DEPTH       = 0,
  parameter int AR_DEPTH      = 2,
  parameter int R_DEPTH       = 0
)(
  input  logic            i_clk,
  input  logic            i_rst,
  rggen_axi4lite_if.slave  slave_if,
  rggen_axi4lite_if.master master_if,
  output logic            o_idle
);
  localparam int ID_W = (ID_WIDTH > 0) ? ID_WIDTH : 1;
  localparam int AX_W = ID_W + ADDRESS_WIDTH + 3;
  localparam int W_W  = BUS_WIDTH + BUS_WIDTH / 8;
  localparam int B_W  = ID_W + 2;
  localparam int R_W  = ID_W + 2 + BUS_WIDTH;

  logic [4:0]      empty;
  logic [AX_W-1:0] aw_out;
  logic [W_W-1:0]  w_out;
  logic [AX_W-1:0] ar_out;
  logic [B_W-1:0]  b_out;
  logic [R_W-1:0]  r_out;

  rggen_axi4lite_register_slice_fifo #(.WIDTH(AX_W), .DEPTH(AW_DEPTH)) u_aw (
    .clk(i_clk), .rst(i_rst),
    .in_valid(slave_if.awvalid), .in_ready(slave_if.awready),
    .in_data({slave_if.awid, slave_if.awaddr, slave_if.awprot}),
    .out_valid(master_if.awvalid), .out_ready(master_if.awready),
    .out_data(aw_out), .empty(empty[0])
  );
  assign {master_if.awid, master_if.awaddr, master_if.awprot} = aw_out;

  rggen_axi4lite_register_slice_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w (
    .clk(i_clk), .rst(i_rst),
    .in_valid(slave_if.wvalid), .in_ready(slave_if.wready),
    .in_data({slave_if.wdata, slave_if.wstrb}),
    .out_valid(master_if.wvalid), .out_ready(master_if.wready),
    .out_data(w_out), .empty(empty[1])
  );
  assign {master_if.wdata, master_if.wstrb} = w_out;

  rggen_axi4lite_register_slice_fifo #(.WIDTH(AX_W), .DEPTH(AR_DEPTH)) u_ar (
    .clk(i_clk), .rst(i_rst),
    .in_valid(slave_if.arvalid), .in_ready(slave_if.arready),
    .in_data({slave_if.arid, slave_if.araddr, slave_if.arprot}),
    .out_valid(master_if.arvalid), .out_ready(master_if.arready),
    .out_data(ar_out), .empty(empty[2])
  );
  assign {master_if.arid, master_if.araddr, master_if.arprot} = ar_out;

  // Response channels flow the other way: downstream pushes, upstream pops.
  rggen_axi4lite_register_slice_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b (
    .clk(i_clk), .rst(i_rst),
    .in_valid(master_if.bvalid), .in_ready(master_if.bready),
    .in_data({master_if.bid, master_if.bresp}),
    .out_valid(slave_if.bvalid), .out_ready(slave_if.bready),
    .out_data(b_out), .empty(empty[3])
  );
  assign {slave_if.bid, slave_if.bresp} = b_out;

  rggen_axi4lite_register_slice_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
    .clk(i_clk), .rst(i_rst),
    .in_valid(master_if.rvalid), .in_ready(master_if.rready),
    .in_data({master_if.rid, master_if.rresp, master_if.rdata}),
    .out_valid(slave_if.rvalid), .out_ready(slave_if.rready),
    .out_data(r_out), .empty(empty[4])
  );
  assign {slave_if.rid, slave_if.rresp, slave_if.rdata} = r_out;

  assign o_idle = &empty;
endmodule

// File: doc/rggen_axi4lite_register_slice.md
# rggen_axi4lite_register_slice

Parametrised AXI4-Lite register slice with an independent FIFO of configurable depth on each of the five channels (AW, W, B, AR, R). It sits between a bus master (or interconnect) and the rggen register block to break timing paths in both directions. Every buffered channel drives fully registered outputs on its receiving side. Depth 0 on a channel makes that channel a plain wire-through.

## Interface
- ID_WIDTH, 0, ID field width; a value of 0 gives a 1-bit clipped ID, as elsewhere in the codebase.
- ADDRESS_WIDTH, 8, AW/AR address width.
- BUS_WIDTH, 32, W/R data width; strobe width is BUS_WIDTH/8.
- AW_DEPTH, 2, write-address FIFO entries (0 = pass-through).
- W_DEPTH, 2, write-data FIFO entries (0 = pass-through).
- B_DEPTH, 0, write-response FIFO entries (0 = pass-through).
- AR_DEPTH, 2, read-address FIFO entries (0 = pass-through).
- R_DEPTH, 0, read-response FIFO entries (0 = pass-through).
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- slave_if  rggen_axi4lite_if.slave  -  upstream side; receives AW/W/AR and returns B/R.
- master_if  rggen_axi4lite_if.master  -  downstream side; issues AW/W/AR and receives B/R.
- o_idle  output  1  high when every buffered FIFO is empty.

## Operation
- Each channel with DEPTH = N ≥ 1 is a circular FIFO with:
  - N entries;
  - read and write pointers, each of width max(1, clog2(N));
  - an occupancy count of width clog2(N+1).
- Payload stored per channel:
  - AW: awid, awaddr, awprot.
  - W: wdata, wstrb.
  - AR: arid, araddr, arprot.
  - B: bid, bresp.
  - R: rid, rresp, rdata.
- Push occurs on input valid && input ready. Pop occurs on output valid && output ready.
- Input ready = (count != N) && !i_rst. Output valid = (count != 0). Output payload = entry at the read pointer.
- Pointers advance by one on push/pop and wrap from N-1 to 0. Non-power-of-two N is supported.
- Simultaneous push and pop leave the count unchanged and advance both pointers.
- Push while full cannot occur, because ready is low. Pop while empty cannot occur, because valid is low.
- Ready depends only on count, never combinationally on the downstream ready, so no ready path crosses the slice.
- With DEPTH = 0, all signals of that channel are connected straight through combinationally.
- Stored payload never changes while it is presented with valid high and not yet accepted (AXI stability).
- AW and W FIFOs are fully independent; no address/data pairing is enforced.
- o_idle = AND of (count == 0) over all channels with DEPTH ≥ 1. o_idle is constant 1 if every depth is 0.

## Timing
- Reset (i_rst high at a rising edge):
  - counts and pointers are set to 0;
  - payload registers are set to 0;
  - buffered valid outputs are 0 and buffered payload outputs are 0;
  - buffered ready outputs are 0 for the whole cycle i_rst is high, and 1 from the first cycle after deassertion;
  - o_idle is 1 from the cycle after the reset edge.
- Reset mid-transfer discards all FIFO contents with no further handshake. Pass-through channels are unaffected.
- Latency: data pushed at edge k is visible on the output side with valid high after edge k, i.e. 1 cycle. Pass-through latency is 0.
- Throughput:
  - N ≥ 2 sustains one transfer per cycle with the downstream always ready.
  - N = 1 sustains one transfer every 2 cycles, because ready is low while the single entry is occupied.
- Backpressure: with output ready held low, exactly N transfers are accepted, then input ready drops on the cycle after the Nth push.
- Full-to-not-full: a pop at edge k raises input ready after edge k. Ready does not rise in the same cycle as the pop.

## Test plan
- **Reset:**
  - Stimulus: hold i_rst high for 3 cycles with slave awvalid = 1.
  - Required: awready, wready, arready = 0 and master_if.awvalid = 0 throughout; after release, ready = 1, o_idle = 1 and payload outputs = 0.
- **Streaming (AW_DEPTH = 2):**
  - Stimulus: 8 back-to-back AW beats, addresses 0x00, 0x04, … 0x1C, with master awready = 1.
  - Required: master sees the same 8 addresses in order on 8 consecutive cycles starting 1 cycle after the first push; no stall.
- **Fill/drain (W_DEPTH = 3):**
  - Stimulus: master wready = 0 while 4 beats wdata = 0xA0..0xA3 are offered.
  - Required: 3 accepted and wready low thereafter; on wready = 1, master receives 0xA0, 0xA1, 0xA2 in order; the 4th beat is then accepted and delivered.
- **Wrap with non-power-of-two (AR_DEPTH = 3):**
  - Stimulus: 10 transfers with random downstream stalls.
  - Required: order preserved across pointer wrap; payload stable while master arvalid && !arready.
- **Response buffering (B_DEPTH = 1, R_DEPTH = 2):**
  - Stimulus: bresp = 2'b10 with bid = 1, and 2 R beats rdata 0x1234 / 0x5678, with slave bready/rready toggling.
  - Required: values delivered intact; master bready low while the B entry is held; o_idle drops while any FIFO holds data.
- **Mid-operation reset:**
  - Stimulus: assert i_rst with 2 AW entries buffered.
  - Required: master awvalid = 0 the next cycle; neither stale entry appears after release.
